// File: rtl/bsg_link_iddr_pkg.sv
// Shared constants and helpers for the IDDR link downstream path.
package bsg_link_iddr_pkg;

  localparam int unsigned lg_token_width_default_lp = 2;
  localparam int unsigned pos_half_offset_lp        = 0;

  function automatic int unsigned neg_half_offset(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned valid_bit_pos(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/bsg_link_fifo_2w1r.sv
// Small FIFO with two in-order write ports and one read port.
// The parent is responsible for never writing more than the free space.
module bsg_link_fifo_2w1r #(
  parameter int unsigned width_p = 127,
  parameter int unsigned els_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       w0_v_i,
  input  logic [width_p-1:0]         w0_data_i,
  input  logic                       w1_v_i,
  input  logic [width_p-1:0]         w1_data_i,
  input  logic                       yumi_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p):0]     count_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_count;
  logic [ptr_w_lp-1:0] w_wptr1;

  // Second write lands one slot after the first only when the first is used.
  assign w_wptr1 = r_wptr + ptr_w_lp'(w0_v_i);

  always_ff @(posedge clk_i) begin
    if (w0_v_i) r_mem[r_wptr]  <= w0_data_i;
    if (w1_v_i) r_mem[w_wptr1] <= w1_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + ptr_w_lp'(w0_v_i) + ptr_w_lp'(w1_v_i);
      r_rptr  <= r_rptr + ptr_w_lp'(yumi_i);
      r_count <= r_count + cnt_w_lp'(w0_v_i) + cnt_w_lp'(w1_v_i) - cnt_w_lp'(yumi_i);
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

endmodule

// File: rtl/bsg_link_iddr_downstream.sv
// IDDR receive unpacker: buffers valid half-words and returns toggle credits.
// Optional sticky drop flag enabled by BSG_LINK_IDDR_DOWNSTREAM_OVERFLOW_EN.
module bsg_link_iddr_downstream
  import bsg_link_iddr_pkg::*;
#(
  parameter int unsigned width_p                         = 128,
  parameter int unsigned fifo_els_p                      = 8,
  parameter int unsigned lg_credit_to_token_decimation_p = lg_token_width_default_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [2*width_p-1:0]   iddr_data_i,
  output logic [width_p-2:0]     data_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic                   token_o,
  output logic                   overflow_o
);

  localparam int unsigned payload_w_lp = width_p - 1;
  localparam int unsigned cnt_w_lp     = $clog2(fifo_els_p) + 1;
  localparam int unsigned tok_w_lp     = lg_credit_to_token_decimation_p;
  localparam int unsigned pos_lo_lp    = pos_half_offset_lp;
  localparam int unsigned neg_lo_lp    = neg_half_offset(width_p);
  localparam int unsigned vbit_lp      = valid_bit_pos(width_p);

  logic                    w_pos_v;
  logic                    w_neg_v;
  logic [payload_w_lp-1:0] w_pos_data;
  logic [payload_w_lp-1:0] w_neg_data;
  logic [cnt_w_lp-1:0]     w_count;
  logic [cnt_w_lp-1:0]     w_free;
  logic                    w_pos_store;
  logic                    w_neg_store;
  logic                    w_deq;
  logic [tok_w_lp-1:0]     r_tok_cnt;
  logic                    r_token;

  assign w_pos_v    = iddr_data_i[pos_lo_lp + vbit_lp];
  assign w_neg_v    = iddr_data_i[neg_lo_lp + vbit_lp];
  assign w_pos_data = iddr_data_i[pos_lo_lp +: payload_w_lp];
  assign w_neg_data = iddr_data_i[neg_lo_lp +: payload_w_lp];

  // Space is judged on the start-of-cycle count; pos claims a slot before neg.
  assign w_free      = cnt_w_lp'(fifo_els_p) - w_count;
  assign w_pos_store = w_pos_v & (w_free != '0);
  assign w_neg_store = w_neg_v & (w_free > cnt_w_lp'(w_pos_store));

  assign v_o   = (w_count != '0);
  assign w_deq = yumi_i & v_o;

  bsg_link_fifo_2w1r #(
    .width_p (payload_w_lp),
    .els_p   (fifo_els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .w0_v_i    (w_pos_store),
    .w0_data_i (w_pos_data),
    .w1_v_i    (w_neg_store),
    .w1_data_i (w_neg_data),
    .yumi_i    (w_deq),
    .data_o    (data_o),
    .count_o   (w_count)
  );

  // Token flips when the dequeue counter wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tok_cnt <= '0;
      r_token   <= 1'b0;
    end else if (w_deq) begin
      r_tok_cnt <= r_tok_cnt + tok_w_lp'(1);
      if (&r_tok_cnt) r_token <= ~r_token;
    end
  end

  assign token_o = r_token;

`ifdef BSG_LINK_IDDR_DOWNSTREAM_OVERFLOW_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = (w_pos_v & ~w_pos_store) | (w_neg_v & ~w_neg_store);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_drop) $warning("bsg_link_iddr_downstream: half-word dropped, buffer full");
  end
`endif

  assign overflow_o = r_overflow;
`else
  assign overflow_o = 1'b0;
`endif

endmodule
